// File: rtl/comp_accum.sv
// comp_accum: sums comp operand pairs over p_len-sample blocks into a 2-deep result FIFO; COMP_ACCUM_SAT_EN adds saturation
module comp_accum #(
  parameter int p_size = 1,
  parameter int p_len = 4,
  parameter int p_acc_w = 2*p_size+8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*p_size-1:0] i_a,
  input  logic [2*p_size-1:0] i_b,
  input  logic               i_dv,
  input  logic               i_clr,
  output logic [p_acc_w-1:0] o_sum,
  output logic               o_sat,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [7:0]         o_cnt,
  output logic               o_ovf
);
  typedef enum logic {IDLE, ACC} state_t;
  state_t state, state_n;
  logic [2*p_size:0] term;
  logic [p_acc_w-1:0] acc, base, nxt;
  logic [p_acc_w-1:0] mem [2];
  logic last, done, pop, push, drop, full, wp, rp;
  logic [1:0] fcnt;
  assign term = {1'b0, i_a} + {1'b0, i_b};
  assign base = state == IDLE ? '0 : acc;
  assign last = o_cnt == 8'(p_len-1);
  assign done = i_dv && last && !i_clr;
  assign o_valid = fcnt != 2'd0;
  assign full = fcnt == 2'd2;
  assign pop = o_valid && i_ready && !i_clr;
  assign push = done && (!full || pop);
  assign drop = done && full && !pop;
  assign o_sum = o_valid ? mem[rp] : '0;
`ifdef COMP_ACCUM_SAT_EN
  logic blk_sat, blk_sat_n;
  logic [p_acc_w:0] raw;
  logic [1:0] sat_mem;
  assign raw = {1'b0, base} + (p_acc_w+1)'(term);
  assign blk_sat_n = blk_sat || raw[p_acc_w];
  assign nxt = blk_sat_n ? '1 : raw[p_acc_w-1:0];
  assign o_sat = o_valid && sat_mem[rp];
  // once a block overflows it stays clamped until the block ends
  always_ff @(posedge clk or negedge rst)
    if (!rst) blk_sat <= 1'b0;
    else if (i_clr || done) blk_sat <= 1'b0;
    else if (i_dv) blk_sat <= blk_sat_n;
  // per-entry saturation flag travels with its FIFO result
  always_ff @(posedge clk or negedge rst)
    if (!rst) sat_mem <= '0;
    else if (push) sat_mem[wp] <= blk_sat_n;
`else
  assign nxt = base + p_acc_w'(term);
  assign o_sat = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // next state: first sample enters ACC, completing sample returns to IDLE
  always_comb begin
    state_n = state;
    if (i_clr) state_n = IDLE;
    else if (i_dv) state_n = last ? IDLE : ACC;
  end
  // block accumulator and sample counter
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc <= '0;
      o_cnt <= '0;
    end else if (i_clr || done) begin
      acc <= '0;
      o_cnt <= '0;
    end else if (i_dv) begin
      acc <= nxt;
      o_cnt <= o_cnt + 8'd1;
    end
  // result FIFO; a pop frees a slot for a push on the same edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem <= '{default: '0};
      wp <= 1'b0;
      rp <= 1'b0;
      fcnt <= '0;
      o_ovf <= 1'b0;
    end else if (i_clr) begin
      wp <= 1'b0;
      rp <= 1'b0;
      fcnt <= '0;
      o_ovf <= 1'b0;
    end else begin
      if (push) mem[wp] <= nxt;
      wp <= wp ^ push;
      rp <= rp ^ pop;
      fcnt <= fcnt + {1'b0, push} - {1'b0, pop};
      o_ovf <= o_ovf | drop;
    end
endmodule
